// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the program-RAM port arbiter: FSM state
//   encoding, requester identifiers and the RAM read/write code.
//   No ports; imported by ram_port_arbiter and rr_arbiter2.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Requester ids double as bit positions in the two-bit request vector.
  localparam logic REQ_L    = 1'b0;
  localparam logic REQ_C    = 1'b1;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Combinational two-way round-robin picker.
//   Ports:
//     req  [1:0] in   raw requests, bit REQ_L = loader, bit REQ_C = core
//     mask [1:0] in   1 = requester currently not eligible
//     last       in   id of the most recently served requester
//     gnt  [1:0] out  one-hot grant (all zero when nobody is eligible)
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  assign eligible = req & ~mask;

  // On a tie the requester that was not served last wins; otherwise the
  // single eligible requester is granted directly.
  always_comb begin
    gnt = 2'b00;
    if (eligible == 2'b11) begin
      gnt = (last == REQ_L) ? 2'b10 : 2'b01;
    end else begin
      gnt = eligible;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single-port program RAM between the UART boot loader (L)
//   and the core fetch/load-store port (C). One access at a time; the RAM
//   window is held for RAM_LATENCY cycles, then a one-cycle ack goes back
//   to the winner together with read data. While boot_mode=1 only L is
//   served.
//   Ports:
//     clk, rst, ce                 clock, sync active-high reset, clock enable
//     boot_mode                    1 = core requests are stalled
//     l_req/l_rw/l_addr/l_wdata    loader request (held until l_ack)
//     l_ack                        loader completion pulse
//     c_req/c_rw/c_addr/c_wdata    core request (held until c_ack)
//     c_ack                        core completion pulse
//     rdata                        last read data, valid with its ack
//     ram_enable/ram_rw/ram_addr/ram_wdata   registered RAM pins
//     ram_rdata                    RAM read data
//     busy                         1 while an access is in progress
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              boot_mode,
  input  logic              l_req,
  input  logic              l_rw,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  input  logic              c_req,
  input  logic              c_rw,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RAM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             winner_q;
  logic             last_q;
  logic [1:0]       gnt;
  logic             grant;
  logic             window_end;

  // Core requests are masked out while the loader owns the RAM.
  rr_arbiter2 u_picker (
    .req  ({c_req, l_req}),
    .mask ({boot_mode, 1'b0}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign grant      = (state_q == IDLE) && (gnt != 2'b00);
  assign window_end = (state_q == ACCESS) && (cnt_q == '0);
  assign busy       = (state_q != IDLE);

  // State register; reset wins over ce so a reset mid-access always
  // drops the RAM window on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a grant opens the window, the counter closes it,
  // and DONE always lasts exactly one enabled cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)      state_d = ACCESS;
      ACCESS:  if (window_end) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath: the request is latched straight into the RAM pin registers
  // at grant so the pins stay stable for the whole window regardless of
  // what the requester does afterwards. The ack register is set as the
  // window closes, which makes it high exactly while the FSM is in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      winner_q   <= REQ_L;
      last_q     <= REQ_L;
      ram_enable <= 1'b0;
      ram_rw     <= RW_READ;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rdata      <= '0;
      l_ack      <= 1'b0;
      c_ack      <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            winner_q   <= gnt[REQ_C];
            ram_rw     <= gnt[REQ_C] ? c_rw    : l_rw;
            ram_addr   <= gnt[REQ_C] ? c_addr  : l_addr;
            ram_wdata  <= gnt[REQ_C] ? c_wdata : l_wdata;
            cnt_q      <= CNT_LOAD;
            ram_enable <= 1'b1;
          end
        end
        ACCESS: begin
          if (window_end) begin
            ram_enable <= 1'b0;
            if (ram_rw == RW_READ) begin
              rdata <= ram_rdata;
            end
            if (winner_q == REQ_C) begin
              c_ack <= 1'b1;
            end else begin
              l_ack <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          l_ack  <= 1'b0;
          c_ack  <= 1'b0;
          last_q <= winner_q;
        end
        default: begin
          ram_enable <= 1'b0;
          l_ack      <= 1'b0;
          c_ack      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Self-checking bench for ram_port_arbiter (RAM_LATENCY=3). The bench
//   plays the RAM itself and keeps a transaction-level reference: a
//   memory image updated when each transaction completes, the expected
//   read data, and the id of the last served requester for tie breaking.
//   Timing expectations are derived arithmetically from the latency.
module tb_ram_port_arbiter;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       boot_mode = 1'b0;
  logic       l_req = 1'b0, l_rw = 1'b0;
  logic [7:0] l_addr = '0, l_wdata = '0;
  logic       l_ack;
  logic       c_req = 1'b0, c_rw = 1'b0;
  logic [7:0] c_addr = '0, c_wdata = '0;
  logic       c_ack;
  logic [7:0] rdata;
  logic       ram_enable, ram_rw;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       busy;
  logic       ram_init = 1'b1;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata;
  logic       model_last;
  logic       rw_a [2];
  logic [7:0] addr_a [2];
  logic [7:0] wd_a [2];

  logic [7:0] mem [256];

  ram_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .RAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .boot_mode(boot_mode),
    .l_req(l_req), .l_rw(l_rw), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .c_req(c_req), .c_rw(c_rw), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .rdata(rdata), .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: data is only driven while enabled so a capture at
  // the wrong moment shows up as X.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB5;
    end else if (ce && ram_enable && ram_rw) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = ram_enable ? mem[ram_addr] : 'x;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setTxn(input int id, input logic rw, input logic [7:0] addr, input logic [7:0] wd);
    rw_a[id] = rw; addr_a[id] = addr; wd_a[id] = wd;
  endtask

  task automatic applyStimulus(input int id);
    if (id == 1) begin
      c_req = 1'b1; c_rw = rw_a[1]; c_addr = addr_a[1]; c_wdata = wd_a[1];
    end else begin
      l_req = 1'b1; l_rw = rw_a[0]; l_addr = addr_a[0]; l_wdata = wd_a[0];
    end
  endtask

  task automatic dropReq(input int id);
    if (id == 1) c_req = 1'b0; else l_req = 1'b0;
  endtask

  // A completed transaction updates the image or the expected read data.
  task automatic applyModel(input int id);
    if (rw_a[id]) ref_mem[addr_a[id]] = wd_a[id];
    else          exp_rdata = ref_mem[addr_a[id]];
  endtask

  // Single-requester transaction; optional ce toggling and boot_mode rise.
  task automatic runTxn(input int id, input bit toggle_ce, input bit raise_boot);
    int first_ack = 0, ack_n = 0, en_n = 0;
    int exp_en = toggle_ce ? 2 * LAT : LAT;
    applyStimulus(id);
    ce = 1'b1;
    applyModel(id);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (toggle_ce) ce = (k % 2 == 0);
      if (raise_boot && k == 1) boot_mode = 1'b1;
      if (ram_enable) begin
        en_n++;
        checkOutput("win_addr", ram_addr, addr_a[id]);
        checkOutput("win_rw", ram_rw, rw_a[id]);
        if (rw_a[id]) checkOutput("win_wdata", ram_wdata, wd_a[id]);
      end
      if (l_ack | c_ack) begin
        ack_n++;
        if (first_ack == 0) first_ack = k;
        checkOutput("ack_owner", {l_ack, c_ack}, (id == 1) ? 2'b01 : 2'b10);
        checkOutput("rdata", rdata, exp_rdata);
        checkOutput("busy_done", busy, 1'b1);
        dropReq(id);
      end else if (first_ack != 0) begin
        break;
      end
    end
    ce = 1'b1;
    checkOutput("ack_time", first_ack, exp_en + 1);
    checkOutput("ack_width", ack_n, toggle_ce ? 2 : 1);
    checkOutput("enable_cycles", en_n, exp_en);
    model_last = id[0];
  endtask

  // Both requesters at once: winner is the one not served last.
  task automatic runPair();
    int winner = (model_last == 1'b0) ? 1 : 0;
    int loser  = 1 - winner;
    int t [2] = '{0, 0};
    int n [2] = '{0, 0};
    int owner;
    applyStimulus(0);
    applyStimulus(1);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (ram_enable) begin
        owner = (k <= LAT + 1) ? winner : loser;
        checkOutput("pair_addr", ram_addr, addr_a[owner]);
        if (rw_a[owner]) checkOutput("pair_wdata", ram_wdata, wd_a[owner]);
      end
      checkOutput("ack_exclusive", l_ack & c_ack, 1'b0);
      for (int id = 0; id < 2; id++) begin
        if ((id == 1) ? c_ack : l_ack) begin
          if (t[id] == 0) begin
            t[id] = k;
            applyModel(id);
          end
          n[id]++;
          checkOutput("pair_rdata", rdata, exp_rdata);
          dropReq(id);
        end
      end
      if (t[0] != 0 && t[1] != 0) break;
    end
    @(negedge clk);
    checkOutput("pair_ack_drop", {l_ack, c_ack}, 2'b00);
    checkOutput("pair_winner_time", t[winner], LAT + 1);
    checkOutput("pair_loser_time", t[loser], 2 * LAT + 3);
    checkOutput("pair_ack_count", n[0] + n[1], 2);
    model_last = loser[0];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB5;
    exp_rdata  = 8'h00;
    model_last = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_ram_enable", ram_enable, 1'b0);
    checkOutput("rst_ram_rw", ram_rw, 1'b0);
    checkOutput("rst_acks", {l_ack, c_ack}, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ram_addr", ram_addr, 8'h00);
    checkOutput("rst_ram_wdata", ram_wdata, 8'h00);
    checkOutput("rst_rdata", rdata, 8'h00);
    rst = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);

    // Loader read of 0x10 (RAM holds 0xA5 there)
    setTxn(0, 1'b0, 8'h10, 8'h00);
    runTxn(0, 1'b0, 1'b0);
    checkOutput("first_read_value", rdata, 8'hA5);

    // Simultaneous writes: core wins the first tie
    setTxn(0, 1'b1, 8'h20, 8'h01);
    setTxn(1, 1'b1, 8'h21, 8'h02);
    runPair();
    setTxn(0, 1'b0, 8'h20, 8'h00);
    runTxn(0, 1'b0, 1'b0);
    setTxn(1, 1'b0, 8'h21, 8'h00);
    runTxn(1, 1'b0, 1'b0);

    // boot_mode stalls the core
    boot_mode = 1'b1;
    setTxn(1, 1'b0, 8'h20, 8'h00);
    applyStimulus(1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("boot_no_enable", ram_enable, 1'b0);
      checkOutput("boot_no_cack", c_ack, 1'b0);
      checkOutput("boot_not_busy", busy, 1'b0);
    end
    boot_mode = 1'b0;
    runTxn(1, 1'b0, 1'b0);

    // boot_mode rising during a core access, then loader-only service
    setTxn(1, 1'b1, 8'h30, 8'h5A);
    runTxn(1, 1'b0, 1'b1);
    setTxn(1, 1'b0, 8'h30, 8'h00);
    applyStimulus(1);
    setTxn(0, 1'b0, 8'h30, 8'h00);
    runTxn(0, 1'b0, 1'b0);
    setTxn(0, 1'b1, 8'h31, 8'h77);
    runTxn(0, 1'b0, 1'b0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("boot_core_stalled", c_ack, 1'b0);
    end
    boot_mode = 1'b0;
    runTxn(1, 1'b0, 1'b0);

    // Clock enable toggling during a loader write
    setTxn(0, 1'b1, 8'h40, 8'h3C);
    runTxn(0, 1'b1, 1'b0);
    setTxn(0, 1'b0, 8'h40, 8'h00);
    runTxn(0, 1'b0, 1'b0);

    // Randomized mix of single and contended transactions
    for (int it = 0; it < 16; it++) begin
      for (int id = 0; id < 2; id++)
        setTxn(id, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 2) == 0) runTxn($urandom_range(0, 1), 1'b0, 1'b0);
      else runPair();
    end

    // Reset in the second enable cycle of a core read
    setTxn(1, 1'b0, 8'h10, 8'h00);
    applyStimulus(1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_enable_before", ram_enable, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    dropReq(1);
    rst = 1'b0;
    model_last = 1'b0;
    exp_rdata  = 8'h00;
    checkOutput("midrst_enable", ram_enable, 1'b0);
    checkOutput("midrst_acks", {l_ack, c_ack}, 2'b00);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_pins", {ram_rw, ram_addr, ram_wdata}, 17'h0);
    checkOutput("midrst_rdata", rdata, 8'h00);
    repeat (5) begin
      @(negedge clk);
      checkOutput("midrst_no_ack", {l_ack, c_ack, busy}, 3'b000);
    end

    // Round-robin pointer is back to loader: core wins the tie again
    setTxn(0, 1'b0, 8'h21, 8'h00);
    setTxn(1, 1'b0, 8'h20, 8'h00);
    runPair();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
